// File: rtl/ap_mem_port_responder.sv
// ap_mem_port_responder: single-port RAM behind an HLS ap_memory port, with a host load/readback port and access statistics
module ap_mem_port_responder #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [ADDR_W-1:0] address0,
  input  logic              ce0,
  input  logic              we0,
  input  logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] q0,
  input  logic              core_busy,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              oob_err
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q0_q, q0_d, hr_q, hr_d, wdata, rd_data;
  logic [CNT_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr;
  logic              hv_q, hv_d, oob_q, oob_d, host_acc, en, we, in_rng;
  assign host_req_ready = ~ap_rst & ~core_busy & ~ce0;
  assign host_acc = host_req_valid & host_req_ready;
  // the core and host never share a cycle, so one muxed port serves both
  assign addr    = ce0 ? address0 : host_addr;
  assign we      = ce0 ? we0 : host_we;
  assign wdata   = ce0 ? d0 : host_wdata;
  assign en      = ce0 | host_acc;
  assign in_rng  = {1'b0, addr} < DEPTH_L;
  assign rd_data = in_rng ? mem[addr] : '0;
  always_ff @(posedge ap_clk)
    if (en & we & in_rng) mem[addr] <= wdata;
  always_comb begin
    q0_d  = (ce0 & ~we0) ? rd_data : q0_q;
    hr_d  = (host_acc & ~host_we) ? rd_data : hr_q;
    hv_d  = host_acc & ~host_we;
    rd_d  = cnt_clr ? '0 : rd_q + CNT_W'(ce0 & ~we0 & ~&rd_q);
    wr_d  = cnt_clr ? '0 : wr_q + CNT_W'(ce0 & we0 & ~&wr_q);
    oob_d = ~cnt_clr & (oob_q | (en & ~in_rng));
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      q0_q  <= '0;
      hr_q  <= '0;
      hv_q  <= 1'b0;
      rd_q  <= '0;
      wr_q  <= '0;
      oob_q <= 1'b0;
    end else begin
      q0_q  <= q0_d;
      hr_q  <= hr_d;
      hv_q  <= hv_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      oob_q <= oob_d;
    end
  end
  // a reset arriving while read data is due cancels the pulse
  assign host_rvalid = hv_q & ~ap_rst;
  assign q0          = q0_q;
  assign host_rdata  = hr_q;
  assign rd_count    = rd_q;
  assign wr_count    = wr_q;
  assign oob_err     = oob_q;
endmodule

// File: tb/tb_ap_mem_port_responder.sv
// tb_ap_mem_port_responder: directed stimulus with a host-read scoreboard and direct status checks
module tb_ap_mem_port_responder;
  localparam int DATA_W = 64, ADDR_W = 8, DEPTH = 200, CNT_W = 4;
  localparam logic [63:0] V3 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] V4 = 64'hDEAD_BEEF_0000_0002;
  logic ap_clk = 0, ap_rst = 1;
  logic [ADDR_W-1:0] address0 = 0, host_addr = 0;
  logic ce0 = 0, we0 = 0, core_busy = 0, host_req_valid = 0, host_we = 0, cnt_clr = 0;
  logic [DATA_W-1:0] d0 = 0, host_wdata = 0;
  logic [DATA_W-1:0] q0, host_rdata;
  logic host_req_ready, host_rvalid, oob_err;
  logic [CNT_W-1:0] rd_count, wr_count;
  logic [63:0] sb[$];
  int total = 0, passed = 0;

  ap_mem_port_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
    .core_busy(core_busy), .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .cnt_clr(cnt_clr), .rd_count(rd_count), .wr_count(wr_count), .oob_err(oob_err));

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk)
    if (host_rvalid) begin
      total = total + 1;
      if (sb.size() == 0)
        $display("FAIL host_rvalid_unexpected: got rdata=%h, required no rvalid", host_rdata);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        if (host_rdata === e) passed = passed + 1;
        else $display("FAIL host_rdata: got %h, required %h", host_rdata, e);
      end
    end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total = total + 1;
    if (a === e) passed = passed + 1;
    else $display("FAIL %s: got %h, required %h", n, a, e);
  endtask

  task automatic host(input logic w, input logic [ADDR_W-1:0] a, input logic [63:0] v);
    host_req_valid = 1; host_we = w; host_addr = a; host_wdata = v;
    if (!w) sb.push_back(v);
    step();
    host_req_valid = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_q0", q0, 0);
    chk("rst_rvalid", 64'(host_rvalid), 0);
    chk("rst_rd", 64'(rd_count), 0);
    chk("rst_wr", 64'(wr_count), 0);
    chk("rst_oob", 64'(oob_err), 0);
    chk("rst_ready", 64'(host_req_ready), 0);
    ap_rst = 0; #1;
    chk("ready_idle", 64'(host_req_ready), 1);
    // preload then back-to-back readback
    host(1, 3, V3);
    host(1, 4, V4);
    host_req_valid = 1; host_we = 0; host_addr = 3; sb.push_back(V3);
    step();
    host_addr = 4; sb.push_back(V4);
    step();
    host_req_valid = 0;
    step();
    // core read latency and hold
    core_busy = 1; ce0 = 1; we0 = 0; address0 = 3; #1;
    chk("ready_core", 64'(host_req_ready), 0);
    step();
    ce0 = 0;
    chk("core_rd_lat", q0, V3);
    step();
    chk("core_rd_hold", q0, V3);
    chk("rd_cnt1", 64'(rd_count), 1);
    // core write no-change, then read-after-write
    ce0 = 1; we0 = 1; d0 = 64'hA5;
    step();
    we0 = 0;
    chk("wr_nochange", q0, V3);
    chk("wr_cnt1", 64'(wr_count), 1);
    step();
    ce0 = 0;
    chk("raw_q0", q0, 64'hA5);
    chk("rd_cnt2", 64'(rd_count), 2);
    // host stalled by busy, then by ce0, then accepted
    host_req_valid = 1; host_we = 0; host_addr = 4; #1;
    chk("stall_busy", 64'(host_req_ready), 0);
    step();
    core_busy = 0; ce0 = 1; #1;
    chk("stall_ce0", 64'(host_req_ready), 0);
    step();
    ce0 = 0; #1;
    chk("accept_ready", 64'(host_req_ready), 1);
    sb.push_back(V4);
    step();
    host_req_valid = 0;
    chk("rd_cnt3", 64'(rd_count), 3);
    step();
    // out of range
    ce0 = 1; we0 = 1; address0 = 250; d0 = 64'h77;
    step();
    we0 = 0;
    step();
    ce0 = 0;
    chk("oob_q0", q0, 0);
    chk("oob_flag", 64'(oob_err), 1);
    chk("oob_wr", 64'(wr_count), 2);
    chk("oob_rd", 64'(rd_count), 4);
    host(0, 250, 0);
    ce0 = 1; address0 = 3; cnt_clr = 1;
    step();
    ce0 = 0; cnt_clr = 0;
    chk("clr_rd", 64'(rd_count), 0);
    chk("clr_wr", 64'(wr_count), 0);
    chk("clr_oob", 64'(oob_err), 0);
    chk("clr_q0", q0, 64'hA5);
    // reset with a host read in flight and a core write on the reset edge
    host_req_valid = 1; host_we = 0; host_addr = 4;
    step();
    host_req_valid = 0; ap_rst = 1; ce0 = 1; we0 = 1; address0 = 5; d0 = 64'h55; #1;
    chk("rst_kill_rvalid", 64'(host_rvalid), 0);
    step();
    ap_rst = 0; ce0 = 0; we0 = 0;
    chk("rst_mid_q0", q0, 0);
    chk("rst_mid_rdata", host_rdata, 0);
    host(0, 4, V4);
    host(0, 5, 64'h55);
    step();
    // saturation
    ce0 = 1; address0 = 3;
    repeat (20) step();
    ce0 = 0;
    chk("sat_rd", 64'(rd_count), 15);
    chk("sat_q0", q0, 64'hA5);
    step(); step();
    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ap_mem_port_responder.md
Name: ap_mem_port_responder

Overview:
- Memory-side responder for the single-port ap_memory interfaces exposed by the HLS accelerator cores, e.g. the weights, inputs and targets arrays.
- Acts as the RAM the core's address0/ce0/we0/d0/q0 pins talk to, with fixed one-cycle read latency.
- Also has a host load/readback port, so testbenches and the SoC wrapper can preload operands and read back results while the core is not accessing memory.
- Keeps access statistics and a sticky out-of-range error flag.

Parameters:
DATA_W, 64, word width of d0/q0 and host data
ADDR_W, 8, width of address0 and host_addr
DEPTH, 256, number of words implemented; must satisfy DEPTH <= 2**ADDR_W
CNT_W, 32, width of the access statistics counters

Ports:
ap_clk  in  1  clock; all logic on rising edge
ap_rst  in  1  synchronous, active-high reset
address0  in  ADDR_W  core word address
ce0  in  1  core chip enable
we0  in  1  core write enable; qualified by ce0
d0  in  DATA_W  core write data
q0  out  DATA_W  core read data
core_busy  in  1  high while the core is between ap_start and ap_done; blocks the host
host_req_valid  in  1  host request valid
host_req_ready  out  1  host request accepted this cycle when valid&ready
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_rvalid  out  1  one-cycle pulse, host read data valid
host_rdata  out  DATA_W  host read data
cnt_clr  in  1  synchronous clear of the counters and the error flag
rd_count  out  CNT_W  core reads served; saturating
wr_count  out  CNT_W  core writes performed; saturating
oob_err  out  1  sticky: some access used address >= DEPTH

Behaviour:
Reset:
- ap_rst clears q0, host_rdata, host_rvalid, rd_count, wr_count and oob_err to 0.
- host_req_ready is 0 during the reset cycle.
- Memory contents are NOT reset.

Core port:
- Read: ce0=1, we0=0 at edge N -> q0 = mem[address0] after edge N. Latency is exactly 1 cycle.
- q0 holds its value whenever ce0=0.
- Write: ce0=1, we0=1 -> mem[address0] <= d0. Mode is no-change: q0 keeps its previous value.
- Read-after-write to the same address on the next cycle returns the new data.
- Each served read increments rd_count by 1; each write increments wr_count by 1.
- Counters saturate at all-ones and do not wrap.

Host port:
- host_req_ready = !ap_rst & !core_busy & !ce0. This is combinational and the core always has priority.
- An access is accepted on a cycle where host_req_valid & host_req_ready.
- Host write: mem[host_addr] <= host_wdata.
- Host read: host_rdata = mem[host_addr] and host_rvalid=1 in the following cycle only.
- host_rdata holds its value otherwise.
- Host accesses do not affect the counters or q0.
- Back-to-back host reads are allowed: one accepted per cycle, one rvalid per cycle, returned in order.

Out of range (address >= DEPTH, either port):
- Writes are dropped.
- Reads return 0.
- oob_err is set and stays set until cnt_clr or ap_rst.
- Counters still increment for out-of-range core accesses.

Simultaneous events:
- Core and host requests in the same cycle: the core is served and the host is stalled.
- cnt_clr together with an access: clear wins; counters read 0 the next cycle.
- ap_rst while a host read is in flight: host_rvalid does not pulse and the request is lost.
- ap_rst mid core operation: q0 is forced to 0; a write on the reset edge is still committed.

Implementation:
- Inferable as a single-port RAM plus registered outputs.
- No combinational path from inputs to q0 or host_rdata.

Test Plan:
1. Host preload and readback: host writes 0x1111_0000_0000_0001 to addr 3 and 0xDEAD_BEEF_0000_0002 to addr 4, then reads 3 and 4 back to back -> host_rvalid high two consecutive cycles, data returned in order.
2. Core read latency: core_busy=1, ce0=1, we0=0, address0=3 -> q0=0x1111_0000_0000_0001 exactly one edge later. With ce0=0 afterwards q0 holds. rd_count=1.
3. Core write, no-change mode: write d0=0xA5 to addr 3 -> q0 unchanged that cycle. Following read of 3 -> q0=0xA5. wr_count=1.
4. Priority: host_req_valid=1 while core_busy=1 or ce0=1 -> host_req_ready=0 and nothing is accepted. Drop core_busy and ce0 -> accepted the same cycle.
5. Out of range with DEPTH=200: core write to addr 250, then read of 250 -> q0=0, oob_err=1. cnt_clr -> oob_err=0, rd_count=0, wr_count=0.
6. Reset mid-op and saturation:
   - ap_rst asserted in the cycle after a host read is accepted -> no host_rvalid, q0=0, memory data preserved.
   - With CNT_W=4, 20 core reads -> rd_count=15.
